// File: rtl/rds_msg_arbiter.sv
// rds_msg_arbiter
// Shares the single-port RDS message BRAM between the RDS modulator, which
// gets every slot the host does not take, and a req/ack host port that is
// granted at most once every three cycles. Host accesses at or above
// C_MSG_LEN never reach the BRAM and complete with host_err set.
//
// Optional feature: define RDS_MSG_ARB_BANK_SWAP_EN for double-buffered
// message banks. The host edits the shadow bank, and a swap request takes
// effect at the next RDS read of address 0.

module rds_msg_arbiter #(
    parameter int C_ADDR_BITS = 9,
    parameter int C_MSG_LEN   = 260
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [C_ADDR_BITS-1:0] rds_addr,
    output logic [7:0]             rds_data,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [C_ADDR_BITS-1:0] host_addr,
    input  logic [7:0]             host_wdata,
    output logic                   host_ack,
    output logic [7:0]             host_rdata,
    output logic                   host_err,
    output logic [C_ADDR_BITS:0]   mem_addr,
    output logic                   mem_we,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata
`ifdef RDS_MSG_ARB_BANK_SWAP_EN
    ,
    input  logic                   swap_req,
    output logic                   swap_done,
    output logic                   active_bank
`endif
);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        H_WAIT = 2'd1,
        H_ACK  = 2'd2
    } state_t;

    // Widened by one bit so a length equal to the full address space still compares correctly.
    localparam logic [C_ADDR_BITS:0] MSG_LEN_L = (C_ADDR_BITS+1)'(C_MSG_LEN);

    state_t     state_r;
    logic [7:0] rds_data_r;
    logic       host_ack_r;
    logic [7:0] host_rdata_r;
    logic       host_err_r;
    logic       rds_slot_q_r;   // previous cycle was an RDS slot
    logic       req_rd_r;       // granted access is a read
    logic       req_err_r;      // granted access is out of range

    logic       host_in_range_s;
    logic       grant_s;
    logic       host_slot_s;
    logic       rds_bank_s;
    logic       host_bank_s;

    assign host_in_range_s = ({1'b0, host_addr} < MSG_LEN_L);
    // Gating with reset_n keeps a request seen during reset from reaching the BRAM.
    assign grant_s         = reset_n && (state_r == ARB) && host_req;
    assign host_slot_s     = grant_s && host_in_range_s;

`ifdef RDS_MSG_ARB_BANK_SWAP_EN
    logic pending_r;
    logic active_bank_r;
    logic swap_done_r;
    logic swap_now_s;

    // The swap lands on the RDS read of address 0, and that read already sees the new bank.
    assign swap_now_s  = !host_slot_s && pending_r && (rds_addr == {C_ADDR_BITS{1'b0}});
    assign rds_bank_s  = active_bank_r ^ swap_now_s;
    assign host_bank_s = ~active_bank_r;
    assign swap_done   = swap_done_r;
    assign active_bank = active_bank_r;

    // Bank bookkeeping: pending flag, active bank toggle and one-cycle done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r     <= 1'b0;
            active_bank_r <= 1'b0;
            swap_done_r   <= 1'b0;
        end else begin
            swap_done_r <= swap_now_s;
            if (swap_now_s) begin
                active_bank_r <= ~active_bank_r;
                pending_r     <= 1'b0;
            end else if (swap_req) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end
`else
    assign rds_bank_s  = 1'b0;
    assign host_bank_s = 1'b0;
`endif

    // BRAM port mux: host slot when a granted access is in range, RDS slot otherwise.
    always_comb begin
        mem_addr  = {rds_bank_s, rds_addr};
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (host_slot_s) begin
            mem_addr  = {host_bank_s, host_addr};
            mem_we    = host_we;
            mem_wdata = host_wdata;
        end else begin
            mem_addr  = {rds_bank_s, rds_addr};
            mem_we    = 1'b0;
            mem_wdata = 8'h00;
        end
    end

    // Arbitration FSM, RDS read capture and registered host response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ARB;
            rds_data_r   <= 8'h00;
            host_ack_r   <= 1'b0;
            host_rdata_r <= 8'h00;
            host_err_r   <= 1'b0;
            rds_slot_q_r <= 1'b0;
            req_rd_r     <= 1'b0;
            req_err_r    <= 1'b0;
        end else begin
            rds_slot_q_r <= !host_slot_s;
            if (rds_slot_q_r) begin
                rds_data_r <= mem_rdata;
            end else begin
                rds_data_r <= rds_data_r;
            end
            case (state_r)
                ARB: begin
                    host_ack_r   <= 1'b0;
                    host_rdata_r <= 8'h00;
                    host_err_r   <= 1'b0;
                    if (host_req) begin
                        req_rd_r  <= !host_we;
                        req_err_r <= !host_in_range_s;
                        state_r   <= H_WAIT;
                    end else begin
                        state_r <= ARB;
                    end
                end
                H_WAIT: begin
                    // mem_rdata now holds the host read issued in the grant cycle.
                    host_ack_r   <= 1'b1;
                    host_err_r   <= req_err_r;
                    host_rdata_r <= (req_rd_r && !req_err_r) ? mem_rdata : 8'h00;
                    state_r      <= H_ACK;
                end
                H_ACK: begin
                    host_ack_r   <= 1'b0;
                    host_rdata_r <= 8'h00;
                    host_err_r   <= 1'b0;
                    state_r      <= ARB;
                end
                default: begin
                    host_ack_r   <= 1'b0;
                    host_rdata_r <= 8'h00;
                    host_err_r   <= 1'b0;
                    state_r      <= ARB;
                end
            endcase
        end
    end

    assign rds_data   = rds_data_r;
    assign host_ack   = host_ack_r;
    assign host_rdata = host_rdata_r;
    assign host_err   = host_err_r;

endmodule

// File: tb/tb_rds_msg_arbiter.sv
// Self-checking bench for rds_msg_arbiter: BRAM model, table-driven host
// accesses, multi-cycle corner cases and randomized traffic checked against
// a byte-array reference of the message store.
// Define RDS_MSG_ARB_BANK_SWAP_EN to exercise the bank-swap feature.

module tb_rds_msg_arbiter;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] rds_addr;
    logic [7:0]    rds_data;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic          host_ack;
    logic [7:0]    host_rdata;
    logic          host_err;
    logic [AW:0]   mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;
`ifdef RDS_MSG_ARB_BANK_SWAP_EN
    logic          swap_req;
    logic          swap_done;
    logic          active_bank;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    logic exp_hbank;            // bank the host is expected to address

    always #20 clk = ~clk;

    rds_msg_arbiter #(.C_ADDR_BITS(AW), .C_MSG_LEN(260)) dut (
        .clk(clk), .reset_n(reset_n), .rds_addr(rds_addr), .rds_data(rds_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_err(host_err), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef RDS_MSG_ARB_BANK_SWAP_EN
        , .swap_req(swap_req), .swap_done(swap_done), .active_bank(active_bank)
`endif
    );

    // Initial contents, identical in both banks; byte 5 holds 0x41.
    function automatic logic [7:0] pat(input logic [8:0] a);
        logic [15:0] t;
        if (a == 9'd5) return 8'h41;
        t = 16'(a) * 16'd37 + 16'd11;
        return t[7:0];
    endfunction

    // BRAM model: 1-cycle synchronous read, read-before-write.
    logic [7:0] bram     [0:1023];
    bit         wr_valid [0:1023];
    always @(posedge clk) begin
        if (mem_we) begin
            bram[mem_addr]     <= mem_wdata;
            wr_valid[mem_addr] <= 1'b1;
        end
        mem_rdata <= wr_valid[mem_addr] ? bram[mem_addr] : pat(mem_addr[8:0]);
    end

    // Reference contents of the message store as the host should see them.
    logic [7:0] ref_mem [0:1023];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One host access: grant expected in the first cycle, ack two cycles later.
    task automatic host_xact(input logic we, input logic [8:0] addr, input logic [7:0] wd,
                             input logic exp_err, input logic chk_rd, input logic [7:0] exp_rd,
                             input string tag);
        int   cyc;
        logic got;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
        @(negedge clk);
        check({tag, "_mem_we"}, mem_we, we && !exp_err);
        if (!exp_err) check({tag, "_mem_addr"}, mem_addr, {exp_hbank, addr});
        if (we && !exp_err) check({tag, "_mem_wdata"}, mem_wdata, wd);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (host_ack) got = 1'b1;
            else check({tag, "_idle_zero"}, {host_err, host_rdata}, 0);
        end
        check({tag, "_ack_latency"}, got ? cyc : 99, 2);
        if (got) begin
            check({tag, "_err"}, host_err, exp_err);
            if (chk_rd) check({tag, "_rdata"}, host_rdata, exp_rd);
            if (we && !exp_err) ref_mem[{exp_hbank, addr}] = wd;
        end
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic [8:0] addr;
        logic [7:0] wdata;
        logic       exp_err;
        logic       chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(9'(i));
`ifdef RDS_MSG_ARB_BANK_SWAP_EN
        exp_hbank = 1'b1;
        swap_req  = 1'b0;
`else
        exp_hbank = 1'b0;
`endif
        vecs[0] = '{1'b1, 9'd10,  8'h55, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 9'd10,  8'h00, 1'b0, 1'b1, 8'h55};
        vecs[2] = '{1'b1, 9'd300, 8'hAA, 1'b1, 1'b1, 8'h00};
        vecs[3] = '{1'b0, 9'd300, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[4] = '{1'b1, 9'd259, 8'hC3, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 9'd259, 8'h00, 1'b0, 1'b1, 8'hC3};
        vecs[6] = '{1'b1, 9'd260, 8'h12, 1'b1, 1'b1, 8'h00};
        vecs[7] = '{1'b0, 9'd260, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[8] = '{1'b0, 9'd0,   8'h00, 1'b0, 1'b1, 8'h0B};
        vecs[9] = '{1'b0, 9'd511, 8'h00, 1'b1, 1'b1, 8'h00};

        // Reset with a write request pending: nothing may reach the BRAM.
        reset_n = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 9'd10;
        host_wdata = 8'hFF; rds_addr = 9'd3;
        repeat (3) @(negedge clk);
        check("rst_rds_data", rds_data, 0);
        check("rst_host_ack", host_ack, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_host_err", host_err, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, {1'b0, 9'd3});
        check("rst_mem_wdata", mem_wdata, 0);
`ifdef RDS_MSG_ARB_BANK_SWAP_EN
        check("rst_active_bank", active_bank, 0);
        check("rst_swap_done", swap_done, 0);
`endif
        @(posedge clk); #1;
        host_req = 1'b0; host_we = 1'b0; rds_addr = 9'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // RDS latency with the host idle: new byte exactly two cycles after the address.
        repeat (4) @(negedge clk);
        check("rds_init", rds_data, 8'h0B);
        @(posedge clk); #1;
        rds_addr = 9'd5;
        @(negedge clk);
        check("lat_c0_we", mem_we, 0);
        @(negedge clk);
        check("lat_c1_old", rds_data, 8'h0B);
        check("lat_c1_we", mem_we, 0);
        @(negedge clk);
        check("lat_c2_new", rds_data, 8'h41);

        // Table of host accesses.
        for (int i = 0; i < 10; i++)
            host_xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
                      vecs[i].chk_rd, vecs[i].exp_rd, $sformatf("vec%0d", i));

        // Request held for 9 cycles: acks at 2, 5, 8 while RDS keeps tracking.
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 9'd20; rds_addr = 9'd7;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check($sformatf("held_ack_c%0d", c), host_ack, (c % 3 == 2));
            check("held_mem_we", mem_we, 0);
            if (c % 3 == 2) check("held_rdata", host_rdata, ref_mem[{exp_hbank, 9'd20}]);
            if (c == 3) check("held_rds_7", rds_data, ref_mem[{1'b0, 9'd7}]);
            if (c == 6) check("held_rds_9", rds_data, ref_mem[{1'b0, 9'd9}]);
            if (c < 8) begin
                @(posedge clk); #1;
                if (c == 2) rds_addr = 9'd9;
            end
        end
        @(posedge clk); #1;
        host_req = 1'b0;

        // Reset during H_WAIT aborts the access without an ack.
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 9'd30;
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ack", host_ack, 0);
        check("mid_rst_outs", {rds_data, host_rdata, host_err, mem_we}, 0);
        @(posedge clk); #1;
        host_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_no_ack", host_ack, 0);
        end
        host_xact(1'b0, 9'd31, 8'h00, 1'b0, 1'b1, ref_mem[{exp_hbank, 9'd31}], "post_rst");

        // Randomized traffic: host on even/out-of-range addresses, RDS on odd ones.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    logic       we;
                    logic [8:0] a;
                    logic       err;
                    we = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) a = 9'(260 + $urandom_range(0, 251));
                    else a = 9'($urandom_range(0, 259));
                    err = (int'(a) >= 260);
                    if (we && !err) a[0] = 1'b0;
                    host_xact(we, a, 8'($urandom_range(0, 255)), err, !we || err,
                              err ? 8'h00 : ref_mem[{exp_hbank, a}], "rnd");
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    logic [8:0] a;
                    @(posedge clk); #1;
                    a = 9'($urandom_range(0, 511));
                    a[0] = 1'b1;
                    rds_addr = a;
                    repeat (5) @(negedge clk);
                    check("rnd_rds_data", rds_data, ref_mem[{1'b0, a}]);
                end
            end
        join

`ifdef RDS_MSG_ARB_BANK_SWAP_EN
        // Bank swap: shadow write, request, then the RDS wrap to 0 flips the bank.
        host_xact(1'b1, 9'd0, 8'h99, 1'b0, 1'b0, 8'h00, "shadow_wr");
        @(posedge clk); #1;
        rds_addr = 9'd100; swap_req = 1'b1;
        @(posedge clk); #1;
        swap_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("swap_wait_done", swap_done, 0);
            check("swap_wait_bank", active_bank, 0);
        end
        @(posedge clk); #1;
        rds_addr = 9'd0;
        begin
            int done_cnt;
            done_cnt = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (c == 0) check("swap_mem_addr", mem_addr, {1'b1, 9'd0});
                if (swap_done) done_cnt++;
                if (c == 2) check("swap_rds_data", rds_data, 8'h99);
            end
            check("swap_done_count", done_cnt, 1);
            check("swap_active_bank", active_bank, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
